// File: rtl/fwd_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_scoreboard
//  Purpose  : Forwarding and load-use hazard unit. Tracks the destination tag
//             of every in-flight instruction from EX (stage 0) through WB
//             (stage DEPTH-1) and derives the EX operand-forwarding selects
//             plus a one-cycle load-use stall toward IF/ID. A saturating
//             16-bit counter records the number of stall cycles.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n          pipeline clock (rising edge), async active-low reset
//    id_valid            ID stage holds a real instruction
//    id_rs, id_rt        ID source registers
//    id_reg_write        ID instruction writes the register file
//    id_mem_read         ID instruction is a load
//    id_dest_reg         ID destination register
//    flush               kill the instruction entering EX this edge
//    stall_cnt_clr       synchronous clear of stall_cnt
//    forward_a/_b        EX operand source: 0 = regfile, k = stage k result
//    stall               hold PC and IF/ID; a bubble enters EX
//    ex_rs, ex_rt        source registers of the instruction in EX
//    stall_cnt           saturating stall-cycle count
// ============================================================================
module fwd_scoreboard #(
    parameter int REG_ADDR_W = 3,
    parameter int DEPTH      = 3,   // legal range 2..8
    parameter int R0_ZERO    = 1,
    parameter int FSEL_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic [REG_ADDR_W-1:0] id_dest_reg,
    input  logic                  flush,
    input  logic                  stall_cnt_clr,
    output logic [FSEL_W-1:0]     forward_a,
    output logic [FSEL_W-1:0]     forward_b,
    output logic                  stall,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [15:0]           stall_cnt
);

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    // ------------------------------------------------------------------------
    // Per-stage tag state. Index 0 is EX, index DEPTH-1 is WB.
    // ------------------------------------------------------------------------
    logic [DEPTH-1:0]      r_valid;
    logic [DEPTH-1:0]      r_reg_write;
    logic [DEPTH-1:0]      r_mem_read;
    logic [REG_ADDR_W-1:0] r_dest [DEPTH];
    logic [REG_ADDR_W-1:0] r_ex_rs;
    logic [REG_ADDR_W-1:0] r_ex_rt;
    logic [15:0]           r_stall_cnt;

    logic [FSEL_W-1:0]     w_fwd_a;
    logic [FSEL_W-1:0]     w_fwd_b;
    logic                  w_stall;

    // A stage only ever produces a value for register r if it is a live
    // register writer targeting r; register 0 is excluded when hardwired.
    function automatic logic f_tag_match(
        input logic                  valid,
        input logic                  reg_write,
        input logic [REG_ADDR_W-1:0] dest,
        input logic [REG_ADDR_W-1:0] r
    );
        logic w_r0_excl;
        w_r0_excl   = (R0_ZERO != 0) && (r == '0);
        f_tag_match = valid & reg_write & (dest == r) & ~w_r0_excl;
    endfunction

    // ------------------------------------------------------------------------
    // Forwarding selects. The loop runs from the oldest stage to the
    // youngest so that the last assignment, the youngest producer, wins.
    // Only register state is read here: no input-to-output path.
    // ------------------------------------------------------------------------
    always_comb begin
        w_fwd_a = '0;
        w_fwd_b = '0;
        if (r_valid[0]) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                if (f_tag_match(r_valid[k], r_reg_write[k], r_dest[k], r_ex_rs)) begin
                    w_fwd_a = FSEL_W'(k);
                end
                if (f_tag_match(r_valid[k], r_reg_write[k], r_dest[k], r_ex_rt)) begin
                    w_fwd_b = FSEL_W'(k);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Load-use hazard: the load in EX has no result until MEM completes, so
    // a dependent instruction in ID must wait one cycle. After that cycle the
    // load sits in stage 2 when the consumer reaches EX.
    // ------------------------------------------------------------------------
    always_comb begin
        w_stall = id_valid & r_valid[0] & r_mem_read[0] &
                  (f_tag_match(r_valid[0], r_reg_write[0], r_dest[0], id_rs) |
                   f_tag_match(r_valid[0], r_reg_write[0], r_dest[0], id_rt));
    end

    // ------------------------------------------------------------------------
    // Tag pipeline. Older stages always advance; stage 0 takes a bubble on
    // flush or stall, otherwise the ID instruction.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= '0;
            r_reg_write <= '0;
            r_mem_read  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_dest[k] <= '0;
            end
            r_ex_rs     <= '0;
            r_ex_rt     <= '0;
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                r_valid[k]     <= r_valid[k-1];
                r_reg_write[k] <= r_reg_write[k-1];
                r_mem_read[k]  <= r_mem_read[k-1];
                r_dest[k]      <= r_dest[k-1];
            end
            if (flush || w_stall) begin
                r_valid[0]     <= 1'b0;
                r_reg_write[0] <= 1'b0;
                r_mem_read[0]  <= 1'b0;
                r_dest[0]      <= '0;
                r_ex_rs        <= '0;
                r_ex_rt        <= '0;
            end else begin
                r_valid[0]     <= id_valid;
                r_reg_write[0] <= id_reg_write;
                r_mem_read[0]  <= id_mem_read;
                r_dest[0]      <= id_dest_reg;
                r_ex_rs        <= id_rs;
                r_ex_rt        <= id_rt;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stall-cycle counter. Clear wins over increment; a stall coinciding
    // with a flush is still a lost fetch cycle and is counted.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (stall_cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign forward_a = w_fwd_a;
    assign forward_b = w_fwd_b;
    assign stall     = w_stall;
    assign ex_rs     = r_ex_rs;
    assign ex_rt     = r_ex_rt;
    assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fwd_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fwd_scoreboard
//  Purpose  : Self-checking bench for fwd_scoreboard. Two instances share the
//             stimulus: u_dut (R0_ZERO=1) and u_nz (R0_ZERO=0). A model keeps
//             an issue log per instance (what entered EX at each edge) and
//             derives forwards/stall/counts from instruction ages.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fwd_scoreboard;

    localparam int DEPTH = 3;
    localparam int AW    = 3;
    localparam int FW    = $clog2(DEPTH);

    logic          clk;
    logic          rst_n;
    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_reg_write;
    logic          id_mem_read;
    logic [AW-1:0] id_dest_reg;
    logic          flush;
    logic          stall_cnt_clr;

    logic [FW-1:0] fa0, fb0, fa1, fb1;
    logic          st0, st1;
    logic [AW-1:0] ers0, ert0, ers1, ert1;
    logic [15:0]   cnt0, cnt1;

    int checks   = 0;
    int failures = 0;

    fwd_scoreboard #(.REG_ADDR_W(AW), .DEPTH(DEPTH), .R0_ZERO(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_dest_reg(id_dest_reg),
        .flush(flush), .stall_cnt_clr(stall_cnt_clr),
        .forward_a(fa0), .forward_b(fb0), .stall(st0), .ex_rs(ers0), .ex_rt(ert0),
        .stall_cnt(cnt0)
    );

    fwd_scoreboard #(.REG_ADDR_W(AW), .DEPTH(DEPTH), .R0_ZERO(0)) u_nz (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_dest_reg(id_dest_reg),
        .flush(flush), .stall_cnt_clr(stall_cnt_clr),
        .forward_a(fa1), .forward_b(fb1), .stall(st1), .ex_rs(ers1), .ex_rt(ert1),
        .stall_cnt(cnt1)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // ------------------------------------------------------------------------
    // Model: per instance, a log of instructions in the order they entered
    // EX (newest at the back, a bubble is logged as all-zero). The entry of
    // age a is the instruction that entered EX a edges ago.
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic          v;
        logic          rw;
        logic          mr;
        logic [AW-1:0] d;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
    } ent_t;

    ent_t        log0[$];
    ent_t        log1[$];
    int unsigned tot[2];

    function automatic ent_t at_age(int inst, int age);
        ent_t e;
        e = '0;
        if (inst == 0) begin
            if (age < log0.size()) e = log0[log0.size() - 1 - age];
        end else begin
            if (age < log1.size()) e = log1[log1.size() - 1 - age];
        end
        return e;
    endfunction

    function automatic bit writes(ent_t e, logic [AW-1:0] r, bit r0z);
        return e.v && e.rw && (e.d == r) && !(r0z && (r == '0));
    endfunction

    // Youngest older-than-EX instruction producing r; 0 if none or EX empty.
    function automatic int exp_fwd(int inst, bit use_rt);
        ent_t          ex;
        ent_t          e;
        logic [AW-1:0] r;
        ex = at_age(inst, 0);
        r  = use_rt ? ex.rt : ex.rs;
        if (!ex.v) return 0;
        for (int a = 1; a < DEPTH; a++) begin
            e = at_age(inst, a);
            if (writes(e, r, inst == 0)) return a;
        end
        return 0;
    endfunction

    function automatic bit exp_stall(int inst);
        ent_t ex;
        ex = at_age(inst, 0);
        return id_valid && ex.v && ex.mr &&
               (writes(ex, id_rs, inst == 0) || writes(ex, id_rt, inst == 0));
    endfunction

    function automatic int exp_cnt(int inst);
        return (tot[inst] > 32'd65535) ? 65535 : int'(tot[inst]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            log0.delete();
            log1.delete();
            tot[0] = 0;
            tot[1] = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit   s;
                ent_t e;
                s = exp_stall(i);
                if (stall_cnt_clr) tot[i] = 0;
                else if (s)        tot[i] = tot[i] + 1;
                if (flush || s) e = '0;
                else e = {id_valid, id_reg_write, id_mem_read, id_dest_reg, id_rs, id_rt};
                if (i == 0) begin
                    log0.push_back(e);
                    if (log0.size() > DEPTH) void'(log0.pop_front());
                end else begin
                    log1.push_back(e);
                    if (log1.size() > DEPTH) void'(log1.pop_front());
                end
            end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Continuous compare of both instances against the model, every cycle.
    initial begin
        forever begin
            ent_t e0;
            ent_t e1;
            @(negedge clk);
            #5;
            e0 = at_age(0, 0);
            e1 = at_age(1, 0);
            chk("m0.forward_a", 32'(fa0),  32'(exp_fwd(0, 1'b0)));
            chk("m0.forward_b", 32'(fb0),  32'(exp_fwd(0, 1'b1)));
            chk("m0.stall",     32'(st0),  32'(exp_stall(0)));
            chk("m0.ex_rs",     32'(ers0), 32'(e0.rs));
            chk("m0.ex_rt",     32'(ert0), 32'(e0.rt));
            chk("m0.stall_cnt", 32'(cnt0), 32'(exp_cnt(0)));
            chk("m1.forward_a", 32'(fa1),  32'(exp_fwd(1, 1'b0)));
            chk("m1.forward_b", 32'(fb1),  32'(exp_fwd(1, 1'b1)));
            chk("m1.stall",     32'(st1),  32'(exp_stall(1)));
            chk("m1.ex_rs",     32'(ers1), 32'(e1.rs));
            chk("m1.ex_rt",     32'(ert1), 32'(e1.rt));
            chk("m1.stall_cnt", 32'(cnt1), 32'(exp_cnt(1)));
        end
    end

    // Drive one ID slot at negedge+1; returns at negedge+2 so literal checks
    // see the state after the previous edge together with these inputs.
    task automatic issue(bit v, logic [AW-1:0] rs, logic [AW-1:0] rt, bit rw, bit mr,
                         logic [AW-1:0] d, bit fl = 1'b0, bit clr = 1'b0);
        @(negedge clk);
        #1;
        id_valid      = v;
        id_rs         = rs;
        id_rt         = rt;
        id_reg_write  = rw;
        id_mem_read   = mr;
        id_dest_reg   = d;
        flush         = fl;
        stall_cnt_clr = clr;
        #1;
    endtask

    task automatic idle();
        issue(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_reg_write = 0; id_mem_read = 0;
        id_dest_reg = 0; flush = 0; stall_cnt_clr = 0;

        // Reset with random inputs: everything must read zero.
        for (int i = 0; i < 4; i++) begin
            issue(1'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                  3'($urandom), 1'($urandom), 1'($urandom));
        end
        chk("rst.forward_a", 32'(fa0), 0);
        chk("rst.stall",     32'(st0), 0);
        chk("rst.ex_rs",     32'(ers0), 0);
        chk("rst.stall_cnt", 32'(cnt0), 0);
        idle();
        rst_n = 1'b1;
        idle();
        idle();

        // Back-to-back ALU dependency, then an older producer at stage 2.
        issue(1, 3'd0, 3'd0, 1, 0, 3'd1);
        issue(1, 3'd1, 3'd7, 0, 0, 3'd2);
        issue(1, 3'd1, 3'd1, 0, 0, 3'd4);
        chk("b2b.forward_a", 32'(fa0), 1);
        chk("b2b.forward_b", 32'(fb0), 0);
        idle();
        chk("age2.forward_a", 32'(fa0), 2);
        chk("age2.forward_b", 32'(fb0), 2);

        // Youngest producer wins.
        issue(1, 3'd0, 3'd0, 1, 0, 3'd7);
        issue(1, 3'd0, 3'd0, 1, 0, 3'd7);
        issue(1, 3'd0, 3'd7, 0, 0, 3'd2);
        idle();
        chk("young.forward_b", 32'(fb0), 1);
        chk("young.forward_a_r0", 32'(fa0), 0);

        // Load-use: one stall, then the consumer sees the load at stage 2.
        issue(1, 3'd0, 3'd0, 1, 1, 3'd3);
        issue(1, 3'd3, 3'd0, 1, 0, 3'd5);
        chk("lu.stall", 32'(st0), 1);
        issue(1, 3'd3, 3'd0, 1, 0, 3'd5);
        chk("lu.stall_release", 32'(st0), 0);
        chk("lu.stall_cnt", 32'(cnt0), 1);
        idle();
        chk("lu.forward_a", 32'(fa0), 2);

        // Register 0 handling on both instances.
        issue(1, 3'd0, 3'd0, 1, 0, 3'd0);
        issue(1, 3'd0, 3'd0, 0, 0, 3'd4);
        idle();
        chk("r0z.forward_a", 32'(fa0), 0);
        chk("r0nz.forward_a", 32'(fa1), 1);
        issue(1, 3'd0, 3'd0, 1, 1, 3'd0);
        issue(1, 3'd0, 3'd0, 0, 0, 3'd4);
        chk("r0z.stall", 32'(st0), 0);
        chk("r0nz.stall", 32'(st1), 1);
        idle();

        // Flush kills a writer; flush together with stall.
        issue(1, 3'd0, 3'd0, 1, 0, 3'd6, 1'b1);
        issue(1, 3'd6, 3'd6, 0, 0, 3'd1);
        chk("flush.valid_ex_rs", 32'(ers0), 0);
        idle();
        chk("flush.forward_a", 32'(fa0), 0);
        chk("flush.forward_b", 32'(fb0), 0);
        issue(1, 3'd0, 3'd0, 1, 1, 3'd2);
        issue(1, 3'd2, 3'd1, 0, 0, 3'd1, 1'b1);
        chk("flush_stall.stall", 32'(st0), 1);
        idle();
        idle();

        // Saturation: preload near the top, then alternate load/stall.
        force u_dut.r_stall_cnt = 16'hFFFC;
        force u_nz.r_stall_cnt  = 16'hFFFC;
        tot[0] = 32'hFFFC;
        tot[1] = 32'hFFFC;
        #1;
        release u_dut.r_stall_cnt;
        release u_nz.r_stall_cnt;
        for (int i = 0; i < 12; i++) begin
            issue(1, 3'd3, 3'd3, 1, 1, 3'd3);
        end
        idle();
        chk("sat.stall_cnt", 32'(cnt0), 32'hFFFF);
        issue(1, 3'd3, 3'd3, 1, 1, 3'd3);
        issue(1, 3'd3, 3'd3, 1, 1, 3'd3, 1'b0, 1'b1);
        chk("clr.stall_with_clr", 32'(st0), 1);
        idle();
        chk("clr.stall_cnt", 32'(cnt0), 0);

        // Asynchronous reset mid-operation drops in-flight tags at once.
        issue(1, 3'd5, 3'd4, 1, 0, 3'd5);
        issue(1, 3'd5, 3'd5, 0, 0, 3'd1);
        rst_n = 1'b0;
        #1;
        chk("arst.ex_rs", 32'(ers0), 0);
        chk("arst.forward_a", 32'(fa0), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        issue(1, 3'd5, 3'd5, 0, 0, 3'd1);
        idle();
        chk("arst.first_forward_a", 32'(fa0), 0);

        // Random traffic against the model.
        for (int i = 0; i < 60; i++) begin
            issue(1'($urandom_range(0, 3) != 0), 3'($urandom), 3'($urandom),
                  1'($urandom), 1'($urandom_range(0, 2) == 0), 3'($urandom),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0));
        end
        idle();
        @(negedge clk);
        #8;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
